// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-stage access unit: dreq_info field
// encodings and the access FSM state type.
package mem_access_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // dreq_info[2]: 1 = zero-extend load data
  localparam int unsigned INFO_UNSIGNED = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_access_align.sv
// Combinational byte-lane helper: store strobe/shift and misalign detection
// for a presented access, plus load extract/extend for a returned word.
module mem_align
  import mem_access_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [1:0]                size,
  input  logic [XLEN-1:0]           wdata,
  output logic [XLEN/8-1:0]         strobe,
  output logic [XLEN-1:0]           wdata_lane,
  output logic                      misaligned,
  input  logic [$clog2(XLEN/8)-1:0] ld_offset,
  input  logic [1:0]                ld_size,
  input  logic                      ld_unsigned,
  input  logic [XLEN-1:0]           rdata,
  output logic [XLEN-1:0]           ld_data
);
  localparam int unsigned STRB_W = XLEN / 8;

  logic [XLEN-1:0] shifted;
  logic            mis_raw;

  always_comb begin
    wdata_lane = wdata << {offset, 3'b000};
    strobe     = '1;
    mis_raw    = 1'b0;
    case (size)
      SIZE_B: strobe = STRB_W'(1) << offset;
      SIZE_H: begin
        strobe  = STRB_W'(3) << offset;
        mis_raw = offset[0];
      end
      SIZE_W: begin
        strobe  = STRB_W'(4'hF) << offset;
        mis_raw = |offset[1:0];
      end
      default: mis_raw = |offset;
    endcase
    misaligned = ALIGN_CHECK && mis_raw;
  end

  always_comb begin
    shifted = rdata >> {ld_offset, 3'b000};
    case (ld_size)
      SIZE_B:  ld_data = {{(XLEN-8){~ld_unsigned & shifted[7]}}, shifted[7:0]};
      SIZE_H:  ld_data = {{(XLEN-16){~ld_unsigned & shifted[15]}}, shifted[15:0]};
      SIZE_W:  ld_data = {{(XLEN-32){~ld_unsigned & shifted[31]}}, shifted[31:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-stage access unit: issues one bus transaction per load/store,
// stalls the pipeline while it is outstanding and forms the write-back value.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned XLEN             = 64,
  parameter bit          ADDR_ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold_i,
  input  logic              DMre_i,
  input  logic              DMwe_i,
  input  logic [2:0]        dreq_info_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  input  logic [XLEN-1:0]   rd_wdata_i,
  output logic              dreq_valid,
  output logic              dreq_write,
  output logic [XLEN-1:0]   dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [XLEN/8-1:0] dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_data,
  output logic              stall_req,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              misalign_o
);
  localparam int unsigned OFFW = $clog2(XLEN/8);

  mem_state_t        state, state_next;
  logic              ld_unsigned;
  logic [XLEN-1:0]   ld_data, ld_data_q, wdata_lane;
  logic [XLEN/8-1:0] strobe;
  logic              misaligned, mem_op, op;

  mem_align #(.XLEN(XLEN), .ALIGN_CHECK(ADDR_ALIGN_CHECK)) u_align (
    .offset      (mem_addr_i[OFFW-1:0]),
    .size        (dreq_info_i[1:0]),
    .wdata       (mem_wdata_i),
    .strobe      (strobe),
    .wdata_lane  (wdata_lane),
    .misaligned  (misaligned),
    .ld_offset   (dreq_addr[OFFW-1:0]),
    .ld_size     (dreq_size),
    .ld_unsigned (ld_unsigned),
    .rdata       (dresp_data),
    .ld_data     (ld_data)
  );

  assign mem_op = DMre_i | DMwe_i;
  assign op     = mem_op & ~misaligned & ~flush;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (op) state_next = BUSY;
      // A flushed access still has to finish on the bus before we go idle.
      BUSY:  if (dresp_data_ok) state_next = flush ? IDLE : DONE;
             else if (flush)    state_next = DRAIN;
      DONE:  if (flush || !hold_i) state_next = IDLE;
      DRAIN: if (dresp_data_ok) state_next = IDLE;
    endcase
  end

  always_comb begin
    dreq_valid = 1'b0;
    stall_req  = 1'b0;
    misalign_o = 1'b0;
    wb_data_o  = rd_wdata_i;
    unique case (state)
      IDLE: begin
        stall_req  = op;
        misalign_o = mem_op & misaligned & ~flush;
      end
      BUSY: begin
        dreq_valid = 1'b1;
        stall_req  = 1'b1;
      end
      DONE: if (!dreq_write) wb_data_o = ld_data_q;
      DRAIN: begin
        dreq_valid = 1'b1;
        stall_req  = op;
        misalign_o = mem_op & misaligned & ~flush;
      end
    endcase
    if (misalign_o) wb_data_o = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dreq_write  <= 1'b0;
      dreq_addr   <= '0;
      dreq_size   <= '0;
      dreq_strobe <= '0;
      dreq_data   <= '0;
      ld_unsigned <= 1'b0;
      ld_data_q   <= '0;
    end else begin
      if (state == IDLE && op) begin
        dreq_write  <= DMwe_i;
        dreq_addr   <= mem_addr_i;
        dreq_size   <= dreq_info_i[1:0];
        dreq_strobe <= strobe;
        dreq_data   <= wdata_lane;
        ld_unsigned <= dreq_info_i[INFO_UNSIGNED];
      end
      if (state == BUSY && dresp_data_ok) ld_data_q <= ld_data;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus randomized accesses compared
// against a byte-level reference model of the access rules.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst, flush, hold_i, DMre_i, DMwe_i;
  logic [2:0]  dreq_info_i;
  logic [63:0] mem_addr_i, mem_wdata_i, rd_wdata_i;
  logic        dreq_valid, dreq_write;
  logic [63:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        stall_req, misalign_o;
  logic [63:0] wb_data_o;

  int unsigned errors = 0, checks = 0, txn_count = 0;

  mem_access #(.XLEN(64), .ADDR_ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .hold_i(hold_i),
    .DMre_i(DMre_i), .DMwe_i(DMwe_i), .dreq_info_i(dreq_info_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .rd_wdata_i(rd_wdata_i),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .stall_req(stall_req), .wb_data_o(wb_data_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && dreq_valid && dresp_data_ok) txn_count++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-granular view of the access rules.
  function automatic int unsigned m_bytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit m_mis(input logic [1:0] sz, input logic [63:0] addr);
    return (addr % m_bytes(sz)) != 0;
  endfunction

  function automatic logic [7:0] m_strobe(input logic [1:0] sz, input logic [63:0] addr);
    logic [7:0] s = '0;
    int unsigned off = int'(addr % 8);
    for (int unsigned i = 0; i < m_bytes(sz); i++) s[off + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_lane(input logic [63:0] wd, input logic [63:0] addr);
    logic [63:0] v = '0;
    int unsigned off = int'(addr % 8);
    for (int unsigned i = off; i < 8; i++) v[8*i +: 8] = wd[8*(i-off) +: 8];
    return v;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [1:0] sz,
                                         input bit uns, input logic [63:0] addr);
    logic [63:0] v = '0;
    int unsigned off = int'(addr % 8);
    int unsigned n = m_bytes(sz);
    for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!uns && n < 8 && v[8*n-1])
      for (int unsigned i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic run_access(input bit is_load, input logic [1:0] sz, input bit uns,
                            input logic [63:0] addr, input logic [63:0] wd,
                            input logic [63:0] rd, input int unsigned waits,
                            input int unsigned holds, input logic [63:0] alu);
    int unsigned stalls = 0;
    int unsigned t0 = txn_count;
    logic [63:0] exp_wb = is_load ? m_load(rd, sz, uns, addr) : alu;
    @(posedge clk); #1;
    DMre_i = is_load; DMwe_i = !is_load; dreq_info_i = {uns, sz};
    mem_addr_i = addr; mem_wdata_i = wd; rd_wdata_i = alu; dresp_data = rd;
    @(negedge clk);
    if (m_mis(sz, addr)) begin
      chk("mis_flag", misalign_o, 1'b1);
      chk("mis_stall", stall_req, 1'b0);
      chk("mis_wb", wb_data_o, 64'd0);
      @(posedge clk); #1; DMre_i = 0; DMwe_i = 0;
      @(negedge clk);
      chk("mis_noreq", dreq_valid, 1'b0);
      chk("mis_txn", txn_count - t0, 0);
      return;
    end
    chk("idle_mis", misalign_o, 1'b0);
    chk("idle_valid", dreq_valid, 1'b0);
    if (stall_req) stalls++;
    for (int unsigned w = 0; w <= waits; w++) begin
      @(posedge clk); #1;
      dresp_data_ok = (w == waits);
      @(negedge clk);
      chk("busy_valid", dreq_valid, 1'b1);
      chk("busy_write", dreq_write, !is_load);
      chk("busy_addr", dreq_addr, addr);
      chk("busy_size", dreq_size, sz);
      chk("busy_strobe", dreq_strobe, m_strobe(sz, addr));
      chk("busy_data", dreq_data, m_lane(wd, addr));
      if (stall_req) stalls++;
    end
    @(posedge clk); #1;
    dresp_data_ok = 0; dresp_data = {$urandom, $urandom}; hold_i = (holds > 0);
    @(negedge clk);
    chk("done_stall", stall_req, 1'b0);
    chk("done_valid", dreq_valid, 1'b0);
    chk("done_wb", wb_data_o, exp_wb);
    for (int unsigned h = 1; h <= holds; h++) begin
      @(posedge clk); #1; hold_i = (h < holds);
      @(negedge clk);
      chk("hold_wb", wb_data_o, exp_wb);
      chk("hold_valid", dreq_valid, 1'b0);
    end
    chk("stall_cycles", stalls, waits + 2);
    @(posedge clk); #1;
    DMre_i = 0; DMwe_i = 0; rd_wdata_i = {$urandom, $urandom};
    @(negedge clk);
    chk("back_idle_stall", stall_req, 1'b0);
    chk("back_idle_wb", wb_data_o, rd_wdata_i);
    chk("txn_once", txn_count - t0, 1);
  endtask

  initial begin
    logic [63:0] a, x;
    logic [1:0] sz;
    int unsigned t0;
    rst = 1; flush = 0; hold_i = 0; DMre_i = 0; DMwe_i = 0; dreq_info_i = '0;
    mem_addr_i = '0; mem_wdata_i = '0; rd_wdata_i = '0; dresp_data_ok = 0; dresp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", dreq_valid, 1'b0);
    chk("rst_stall", stall_req, 1'b0);
    chk("rst_addr", dreq_addr, 64'd0);
    chk("rst_strobe", dreq_strobe, 8'd0);
    chk("rst_data", dreq_data, 64'd0);
    chk("rst_mis", misalign_o, 1'b0);
    #1 rst = 0;

    // LB 0x1003, data_ok first BUSY cycle
    run_access(1, 2'd0, 0, 64'h1003, 64'h0, 64'h00000000_80000000, 0, 0, 64'h55);
    // LHU 0x1006
    run_access(1, 2'd1, 1, 64'h1006, 64'h0, 64'hBEEF0000_00000000, 1, 0, 64'h66);
    // SW 0x2004, 3 wait cycles
    run_access(0, 2'd2, 0, 64'h2004, 64'h12345678, 64'h0, 3, 0, 64'h77);
    // LD 0x3004 misaligned
    run_access(1, 2'd3, 0, 64'h3004, 64'h0, 64'h0, 0, 0, 64'h88);
    // DONE held by another stall source for 3 cycles
    run_access(1, 2'd2, 0, 64'h4008, 64'h0, 64'h0000000F_FFFFFFFF, 0, 3, 64'h99);

    // flush while idle: no request
    @(posedge clk); #1;
    DMre_i = 1; dreq_info_i = 3'b010; mem_addr_i = 64'h7000; flush = 1;
    @(negedge clk);
    chk("fl_idle_stall", stall_req, 1'b0);
    @(posedge clk); #1; flush = 0; DMre_i = 0;
    @(negedge clk);
    chk("fl_idle_noreq", dreq_valid, 1'b0);

    // flush mid-transaction drains the bus, then a waiting load proceeds
    t0 = txn_count;
    @(posedge clk); #1;
    DMre_i = 1; dreq_info_i = 3'b010; mem_addr_i = 64'h5008; rd_wdata_i = 64'hA1;
    @(posedge clk); #1;
    @(negedge clk); chk("dr_busy_valid", dreq_valid, 1'b1);
    @(posedge clk); #1; flush = 1; DMre_i = 0;
    @(negedge clk); chk("dr_flush_stall", stall_req, 1'b1);
    @(posedge clk); #1; flush = 0; rd_wdata_i = 64'hA2;
    @(negedge clk);
    chk("dr_valid", dreq_valid, 1'b1);
    chk("dr_stall", stall_req, 1'b0);
    chk("dr_wb", wb_data_o, 64'hA2);
    @(posedge clk); #1;
    DMre_i = 1; dreq_info_i = 3'b011; mem_addr_i = 64'h6000; dresp_data_ok = 1;
    @(negedge clk);
    chk("dr_newop_stall", stall_req, 1'b1);
    chk("dr_addr_kept", dreq_addr, 64'h5008);
    @(posedge clk); #1; dresp_data_ok = 0;
    @(negedge clk);
    chk("dr_idle_valid", dreq_valid, 1'b0);
    chk("dr_idle_stall", stall_req, 1'b1);
    x = {$urandom, $urandom};
    @(posedge clk); #1; dresp_data_ok = 1; dresp_data = x;
    @(negedge clk); chk("dr_new_addr", dreq_addr, 64'h6000);
    @(posedge clk); #1; dresp_data_ok = 0;
    @(negedge clk); chk("dr_new_wb", wb_data_o, x);
    @(posedge clk); #1; DMre_i = 0;
    @(negedge clk); chk("dr_txn", txn_count - t0, 2);

    // reset in the middle of a transaction
    @(posedge clk); #1; DMwe_i = 1; dreq_info_i = 3'b000; mem_addr_i = 64'h9001;
    @(posedge clk); #1; rst = 1; DMwe_i = 0;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("rst_mid_valid", dreq_valid, 1'b0);
    chk("rst_mid_addr", dreq_addr, 64'd0);
    chk("rst_mid_stall", stall_req, 1'b0);

    for (int i = 0; i < 24; i++) begin
      sz = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~64'(m_bytes(sz) - 1);
      run_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                 {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 3), $urandom_range(0, 2), {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-stage access unit; consumes the EX/MEM register outputs: DMre, DMwe, dreq_info, mem_addr, mem_wdata, WBsel, RFwe, rdaddr, rd_wdata.
- Drives the data bus through a valid/data_ok handshake and aligns and extends load data.
- Raises a stall request to the ctrl unit while an access is outstanding.
- Presents the write-back result to the MEM/WB register.

Parameters:
- XLEN, 64, data and address width.
- ADDR_ALIGN_CHECK, 1, when 1, misaligned accesses raise misalign_o and issue no bus request.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush from ctrl
- hold_i  in  1  ex_mem held by another stall source (stall[3] without our request)
- DMre_i  in  1  load
- DMwe_i  in  1  store
- dreq_info_i  in  3  [1:0] size: 0=B, 1=H, 2=W, 3=D; [2] 1=zero-extend load
- mem_addr_i  in  64  byte address
- mem_wdata_i  in  64  store data, LSB-aligned
- rd_wdata_i  in  64  ALU result passed through for non-load instructions
- dreq_valid  out  1  bus request valid
- dreq_write  out  1  1=store
- dreq_addr  out  64  address
- dreq_size  out  2  size
- dreq_strobe  out  8  byte enables
- dreq_data  out  64  store data shifted to its byte lane
- dresp_data_ok  in  1  transaction complete
- dresp_data  in  64  raw 64-bit read word
- stall_req  out  1  to ctrl; requests a freeze of stages 0..3
- wb_data_o  out  64  final rd write data
- misalign_o  out  1  misaligned access detected

Behaviour:
- FSM states: IDLE, BUSY, DONE, DRAIN. Reset: IDLE; every registered output cleared to 0.
- op = (DMre_i | DMwe_i) & ~misaligned & ~flush.
- Misaligned: (H and addr[0]) or (W and addr[1:0]!=0) or (D and addr[2:0]!=0).

Per-state behaviour:
- IDLE
  - op=1: stall_req=1 combinationally; latch addr, size, strobe, shifted data, write and sign bit; go to BUSY.
  - Otherwise: wb_data_o=rd_wdata_i and stall_req=0.
- BUSY
  - dreq_valid=1; all dreq_* fields stable until data_ok; stall_req=1.
  - dresp_data_ok=1 in the same cycle: capture the extracted load data; go to DONE. Data_ok in the first BUSY cycle is legal.
- DONE
  - stall_req=0; wb_data_o=captured load data for a load, rd_wdata_i for a store.
  - hold_i=1: stay in DONE and issue no new request.
  - Otherwise: go to IDLE next cycle. MEM/WB captures in the DONE cycle.
- DRAIN
  - dreq_valid stays 1; stall_req=0; result discarded.
  - On data_ok, go to IDLE.
  - While in DRAIN a new op is not accepted; it is stalled with stall_req=1 until drain completes.

Bus-side rules:
- strobe: B=1<<addr[2:0]; H=3<<addr[2:0]; W=0x0F<<addr[2:0]; D=0xFF.
- dreq_data = wdata << (8*addr[2:0]).
- Load extract: rdata >> (8*addr[2:0]), truncate to size, sign- or zero-extend per dreq_info[2].
- D loads are never extended.

Boundary cases:
- flush in BUSY: go to DRAIN. The bus is never abandoned mid-transaction.
- flush in IDLE or DONE: go to IDLE; no request issued.
- rst mid-transaction: go to IDLE immediately. The bus slave is reset by the same rst.
- Misaligned access: misalign_o=1 for the cycle the instruction is presented; no stall and no bus request; wb_data_o=0.
- Latency: a load with data_ok in the first BUSY cycle gives stall_req high for 2 cycles. Each extra wait cycle adds 1.

Decomposition:
- Shared package: dreq_info field constants (SIZE_B/H/W/D, UNSIGNED bit) and the FSM state enum mem_state_t.
- Sub-module: mem_align. Combinational; computes strobe, store shift, load extract/extend and the misalign flag; reusable by a future fetch unit.

Test Plan:
- LB, addr 0x1003, dresp_data 0x00000000_80000000 with data_ok on the first BUSY cycle -> strobe 0x08; wb_data_o 0xFFFFFFFF_FFFFFF80; stall_req high 2 cycles.
- LHU, addr 0x1006, dresp_data 0xBEEF0000_00000000 -> wb_data_o 0x00000000_0000BEEF.
- SW, addr 0x2004, wdata 0x12345678, data_ok after 3 wait cycles -> dreq_data 0x12345678_00000000; strobe 0xF0; fields stable; stall_req high 5 cycles.
- LD, addr 0x3004 -> misalign_o=1; dreq_valid never asserted; stall_req=0.
- Load in BUSY, flush, data_ok 2 cycles later -> DRAIN; dreq_valid held until data_ok; stall_req=0; no write-back.
- DONE with hold_i=1 for 3 cycles -> single bus transaction only; wb_data_o stable; return to IDLE after hold_i drops.
